euler_fetch_ctrl: RTL and testbench

// Sequencer for the Euler fetch stage. It drives init_start, enable, finished_one_row
// and final_done so the matrix/vector PCs walk an N x N row-major matrix against an
// N-vector, once per Euler step, for num_steps steps. Sits between the top-level Euler

---
 rtl/euler_fetch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_euler_fetch_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/euler_fetch_ctrl.sv
// rtl/euler_fetch_ctrl.sv - fetch-stage sequencer walking an N x N matrix per Euler step.
// Optional EULER_FETCH_CTRL_PERF_EN adds a saturating stall-cycle counter.
module euler_fetch_ctrl #(
  parameter int DIM_W  = 8,
  parameter int STEP_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim,
  input  logic [STEP_W-1:0] num_steps,
  input  logic              stall,
  output logic              init_start,
  output logic              enable,
  output logic              finished_one_row,
  output logic              final_done,
  output logic [DIM_W-1:0]  row_idx,
  output logic [DIM_W-1:0]  col_idx,
  output logic [STEP_W-1:0] step_idx,
  output logic              data_valid,
  output logic              data_last,
  output logic              busy,
  output logic              done,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [2:0] {IDLE, INIT, FETCH, ROW_END, STEP_END, DONE} state_t;

  state_t            state;
  logic [DIM_W-1:0]  dim_q;
  logic [STEP_W-1:0] steps_q;
  logic              strobe;
  logic              strobe_last;
  logic              last_col;

  assign last_col    = (col_idx == dim_q - DIM_W'(1));
  assign strobe      = (state == FETCH) && !stall;
  assign strobe_last = strobe && last_col;
  // STEP_END also pulses enable so fetch_stage reloads the matrix PC; it is not a fetch.
  assign enable      = strobe || final_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      dim_q            <= '0;
      steps_q          <= '0;
      row_idx          <= '0;
      col_idx          <= '0;
      step_idx         <= '0;
      init_start       <= 1'b0;
      finished_one_row <= 1'b0;
      final_done       <= 1'b0;
      done             <= 1'b0;
      busy             <= 1'b0;
    end else begin
      init_start       <= 1'b0;
      finished_one_row <= 1'b0;
      final_done       <= 1'b0;
      done             <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dim_q    <= dim;
            steps_q  <= num_steps;
            busy     <= 1'b1;
            row_idx  <= '0;
            col_idx  <= '0;
            step_idx <= '0;
            if (dim == '0 || num_steps == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= INIT;
              init_start <= 1'b1;
            end
          end
        end
        INIT: begin
          row_idx  <= '0;
          col_idx  <= '0;
          step_idx <= '0;
          state    <= FETCH;
        end
        FETCH: begin
          if (!stall) begin
            if (last_col) begin
              if (row_idx == dim_q - DIM_W'(1)) begin
                state      <= STEP_END;
                final_done <= 1'b1;
              end else begin
                state            <= ROW_END;
                finished_one_row <= 1'b1;
              end
            end else begin
              col_idx <= col_idx + DIM_W'(1);
            end
          end
        end
        ROW_END: begin
          col_idx <= '0;
          row_idx <= row_idx + DIM_W'(1);
          state   <= FETCH;
        end
        STEP_END: begin
          row_idx <= '0;
          col_idx <= '0;
          if (step_idx == steps_q - STEP_W'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            step_idx <= step_idx + STEP_W'(1);
            state    <= FETCH;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (RD_LAT == 0) begin : g_comb
      assign data_valid = strobe;
      assign data_last  = strobe_last;
    end else begin : g_pipe
      logic [RD_LAT-1:0] valid_q;
      logic [RD_LAT-1:0] last_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= '0;
          last_q  <= '0;
        end else begin
          valid_q[0] <= strobe;
          last_q[0]  <= strobe_last;
          for (int i = 1; i < RD_LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            last_q[i]  <= last_q[i-1];
          end
        end
      end
      assign data_valid = valid_q[RD_LAT-1];
      assign data_last  = last_q[RD_LAT-1];
    end
  endgenerate

`ifdef EULER_FETCH_CTRL_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state == IDLE && start) begin
      stall_q <= '0;
    end else if (state == FETCH && stall && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_euler_fetch_ctrl.sv
// tb/tb_euler_fetch_ctrl.sv - scoreboard bench for euler_fetch_ctrl at RD_LAT 0, 1 and 3.
module tb_euler_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  dim = '0;
  logic [15:0] num_steps = '0;
  logic        stall = 1'b0;

  logic        init_start, enable, finished_one_row, final_done, data_valid, data_last, busy, done;
  logic [7:0]  row_idx, col_idx;
  logic [15:0] step_idx;
  logic [31:0] stall_cycles;

  logic        i0, e0, f0, d0, v0, l0, b0, n0, i3, e3, f3, d3, v3, l3, b3, n3;
  logic [7:0]  r0, c0, r3, c3;
  logic [15:0] s0, s3;
  logic [31:0] sc0, sc3;

  always #5 clk = ~clk;

  euler_fetch_ctrl #(.DIM_W(8), .STEP_W(16), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .start(start), .dim(dim), .num_steps(num_steps), .stall(stall),
    .init_start(init_start), .enable(enable), .finished_one_row(finished_one_row),
    .final_done(final_done), .row_idx(row_idx), .col_idx(col_idx), .step_idx(step_idx),
    .data_valid(data_valid), .data_last(data_last), .busy(busy), .done(done),
    .stall_cycles(stall_cycles));

  euler_fetch_ctrl #(.DIM_W(8), .STEP_W(16), .RD_LAT(0)) dut_lat0 (
    .clk(clk), .reset(reset), .start(start), .dim(dim), .num_steps(num_steps), .stall(stall),
    .init_start(i0), .enable(e0), .finished_one_row(f0), .final_done(d0),
    .row_idx(r0), .col_idx(c0), .step_idx(s0), .data_valid(v0), .data_last(l0),
    .busy(b0), .done(n0), .stall_cycles(sc0));

  euler_fetch_ctrl #(.DIM_W(8), .STEP_W(16), .RD_LAT(3)) dut_lat3 (
    .clk(clk), .reset(reset), .start(start), .dim(dim), .num_steps(num_steps), .stall(stall),
    .init_start(i3), .enable(e3), .finished_one_row(f3), .final_done(d3),
    .row_idx(r3), .col_idx(c3), .step_idx(s3), .data_valid(v3), .data_last(l3),
    .busy(b3), .done(n3), .stall_cycles(sc3));

  typedef struct packed {
    logic        init, en, fr, fd, dn, bz, sb, ls;
    logic [7:0]  row, col;
    logic [15:0] step;
    logic        chk_cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   exp_stalls = 0;
  logic [3:0] hs = '0;
  logic [3:0] hl = '0;

  task automatic check(input string tag, input int cyc, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic push(input logic i, en, fr, fd, dn, bz, sb, ls,
                      input int r, input int cl, input int st, input logic cc);
    exp_t e;
    e.init = i; e.en = en; e.fr = fr; e.fd = fd; e.dn = dn; e.bz = bz; e.sb = sb; e.ls = ls;
    e.row = 8'(r); e.col = 8'(cl); e.step = 16'(st); e.chk_cnt = cc;
    q.push_back(e);
  endtask

  // Independent reference walk: one entry per cycle after the start cycle.
  task automatic build(input int n, input int s, input int sf, input int st);
    int c;
    exp_stalls = 0;
    if (n == 0 || s == 0) begin
      push(0,0,0,0,1,1,0,0, 0,0,0, 1);
    end else begin
      push(1,0,0,0,0,1,0,0, 0,0,0, 1);
      c = 2;
      for (int stp = 0; stp < s; stp++)
        for (int r = 0; r < n; r++)
          for (int cl = 0; cl < n; cl++) begin
            while (c >= sf && c <= st) begin
              push(0,0,0,0,0,1,0,0, r,cl,stp, 1);
              exp_stalls++; c++;
            end
            push(0,1,0,0,0,1,1,(cl == n-1), r,cl,stp, 1); c++;
            if (cl == n-1) begin
              if (r < n-1) push(0,0,1,0,0,1,0,0, r,cl,stp, 1);
              else         push(0,1,0,1,0,1,0,0, r,cl,stp, 1);
              c++;
            end
          end
      push(0,0,0,0,1,1,0,0, 0,0,s-1, 1);
    end
    for (int k = 0; k < 3; k++) push(0,0,0,0,0,0,0,0, 0,0,0, 0);
  endtask

  task automatic compare_cycle(input exp_t e, input int c);
    hs = {hs[2:0], e.sb};
    hl = {hl[2:0], e.ls};
    check("strobes", c, 40'({init_start, enable, finished_one_row, final_done, done, busy}),
          40'({e.init, e.en, e.fr, e.fd, e.dn, e.bz}));
    if (e.chk_cnt)
      check("counters", c, 40'({row_idx, col_idx, step_idx}), 40'({e.row, e.col, e.step}));
    check("lat1_valid_last", c, 40'({data_valid, data_last}), 40'({hs[1], hl[1]}));
    check("lat0_valid_last", c, 40'({v0, l0}), 40'({hs[0], hl[0]}));
    check("lat3_valid_last", c, 40'({v3, l3}), 40'({hs[3], hl[3]}));
  endtask

  task automatic run_case(input int n, input int s, input int sf, input int st, input int rc);
    exp_t e;
    int   c;
    build(n, s, sf, st);
    @(posedge clk); #1;
    start = 1'b1; dim = 8'(n); num_steps = 16'(s); stall = 1'b0;
    hs = {hs[2:0], 1'b0};
    hl = {hl[2:0], 1'b0};
    c = 1;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk); #1;
      start = (c == rc);
      dim = 8'd7; num_steps = 16'd9;
      stall = (c >= sf && c <= st);
      @(negedge clk);
      compare_cycle(e, c);
      c++;
    end
`ifdef EULER_FETCH_CTRL_PERF_EN
    check("stall_cycles", c, 40'(stall_cycles), 40'(exp_stalls));
`else
    check("stall_cycles", c, 40'(stall_cycles), 40'd0);
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outputs", 0,
          40'({init_start, enable, finished_one_row, final_done, data_valid, data_last, busy, done,
               row_idx, col_idx, step_idx}), 40'd0);
    reset = 1'b0;
    @(negedge clk);

    run_case(2, 1, 0, 0, 0);
    run_case(3, 2, 0, 0, 3);
    run_case(2, 1, 3, 5, 0);
    run_case(3, 1, 4, 9, 0);
    run_case(0, 4, 0, 0, 1);
    run_case(3, 0, 0, 0, 1);

    @(posedge clk); #1;
    start = 1'b1; dim = 8'd3; num_steps = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_lat1", 0,
          40'({init_start, enable, finished_one_row, final_done, data_valid, data_last, busy, done,
               row_idx, col_idx, step_idx}), 40'd0);
    check("async_reset_lat03", 0, 40'({v0, l0, v3, l3, e0, e3, b0, b3}), 40'd0);
    @(negedge clk);
    reset = 1'b0;
    hs = '0; hl = '0;
    run_case(2, 2, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
